// File: rtl/aes_key_expand_if.sv
// Handshake/bus bundle for the AES-128 key expander.
//   slave  : the expander (consumes start/key_in/rk_ready, drives the rest)
//   master : the controller/consumer side
// Signals:
//   start     - one-cycle request to expand key_in
//   key_in    - 128-bit cipher key, w0 = [127:96] .. w3 = [31:0]
//   rk_ready  - consumer ready for the current round key
//   round_key - current round key
//   round_idx - index of round_key
//   rk_valid  - round_key/round_idx valid
//   busy      - expansion in progress
//   done      - one-cycle pulse after the final round key is accepted
//   last_key  - final round key of the most recent completed run
interface aes_key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;
  logic [127:0] last_key;

  modport slave (
    input  start, key_in, rk_ready,
    output round_key, round_idx, rk_valid, busy, done, last_key
  );

  modport master (
    output start, key_in, rk_ready,
    input  round_key, round_idx, rk_valid, busy, done, last_key
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 forward key expander.
// Streams round keys 0..NUM_ROUNDS over a valid/ready handshake, one per
// accepted transfer, reusing a single round of expansion logic (four S-box
// lookups plus Rcon). The final round key is retained in last_key to seed the
// decryption-side inverse key generator.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset
//   kx   - aes_key_expand_if.slave bundle (start, key_in, rk_ready in;
//          round_key, round_idx, rk_valid, busy, done, last_key out)
// Parameter NUM_ROUNDS: legal range 1..10, 10 = full AES-128.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; outputs hold, rk_valid = 0
// EMIT   | round_key/round_idx offered with rk_valid = 1
// FINISH | done pulse, busy = 0; returns to IDLE next cycle
module aes_key_expand_seq #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic            clk,
  input  logic            rst,
  aes_key_expand_if.slave kx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  // Forward AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset (255 - a) * 8, and 255 - a == ~a.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] base;
    base = {~a, 3'b000};
    return SBOX_FLAT[base +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         rk_valid_q, rk_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] last_key_q, last_key_d;

  // One expansion round, driven only from the round_key register.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, temp_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  always_comb begin
    w0       = round_key_q[127:96];
    w1       = round_key_q[95:64];
    w2       = round_key_q[63:32];
    w3       = round_key_q[31:0];
    rot_w    = {w3[23:0], w3[31:24]};
    sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    temp_w   = sub_w ^ {rcon(round_idx_q), 24'h000000};
    n0       = w0 ^ temp_w;
    n1       = n0 ^ w1;
    n2       = n1 ^ w2;
    n3       = n2 ^ w3;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    rk_valid_d  = rk_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    last_key_d  = last_key_q;
    case (state_q)
      IDLE: begin
        if (kx.start) begin
          round_key_d = kx.key_in;
          round_idx_d = 4'd0;
          rk_valid_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        // rk_valid is always high here, so rk_ready alone marks a transfer.
        if (kx.rk_ready) begin
          if (round_idx_q == LAST_IDX) begin
            last_key_d = round_key_q;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = FINISH;
          end else begin
            round_key_d = next_key;
            round_idx_d = round_idx_q + 4'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        rk_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_key_q  <= '0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      rk_valid_q  <= rk_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_key_q  <= last_key_d;
    end
  end

  assign kx.round_key = round_key_q;
  assign kx.round_idx = round_idx_q;
  assign kx.rk_valid  = rk_valid_q;
  assign kx.busy      = busy_q;
  assign kx.done      = done_q;
  assign kx.last_key  = last_key_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: a full-length instance and a
// NUM_ROUNDS=3 instance, checked against a word-recurrence key schedule model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand_seq;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  logic clk;
  logic rst;

  aes_key_expand_if kx ();
  aes_key_expand_if kx3 ();

  aes_key_expand_seq #(.NUM_ROUNDS(10)) u_dut (
    .clk (clk),
    .rst (rst),
    .kx  (kx)
  );

  aes_key_expand_seq #(.NUM_ROUNDS(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .kx  (kx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] mk [0:10];

  int xfers = 0, dones = 0;
  int xfers3 = 0, dones3 = 0;
  int exp_idx = 0, exp_idx3 = 0;
  bit done_due = 1'b0, done_due3 = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] a);
    logic [7:0] r, base, s;
    int e;
    r = 8'h01;
    base = a;
    e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, base);
      base = gmul(base, base);
      e = e / 2;
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_model(t[31:24]), sbox_model(t[23:16]), sbox_model(t[15:8]), sbox_model(t[7:0])}
            ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_idx  = 0;
      done_due = 1'b0;
    end else begin
      chk("busy_vs_valid", kx.busy, kx.rk_valid);
      chk("done_timing", kx.done, done_due);
      if (kx.done) begin
        dones++;
        chk("done_last_key", kx.last_key, mk[10]);
      end
      done_due = 1'b0;
      if (kx.rk_valid) begin
        chk("stream_idx", kx.round_idx, exp_idx);
        chk("stream_key", kx.round_key, mk[exp_idx]);
        if (kx.rk_ready) begin
          xfers++;
          if (exp_idx == 10) begin
            done_due = 1'b1;
            exp_idx  = 0;
          end else begin
            exp_idx++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_idx3  = 0;
      done_due3 = 1'b0;
    end else begin
      chk("r3_done_timing", kx3.done, done_due3);
      if (kx3.done) begin
        dones3++;
        chk("r3_done_last_key", kx3.last_key, mk[3]);
      end
      done_due3 = 1'b0;
      if (kx3.rk_valid) begin
        chk("r3_stream_idx", kx3.round_idx, exp_idx3);
        chk("r3_stream_key", kx3.round_key, mk[exp_idx3]);
        if (kx3.rk_ready) begin
          xfers3++;
          if (exp_idx3 == 3) begin
            done_due3 = 1'b1;
            exp_idx3  = 0;
          end else begin
            exp_idx3++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [127:0] k);
    kx.key_in = k;
    kx.start  = 1'b1;
    @(posedge clk); #1;
    kx.start  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!kx.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  int lat, cyc, x0, d0;
  bit stalled [0:15];
  logic [127:0] hold_key;
  logic [3:0] hold_idx;

  initial begin
    rst = 1'b1;
    kx.start = 1'b0;  kx.key_in = '0;  kx.rk_ready = 1'b0;
    kx3.start = 1'b0; kx3.key_in = '0; kx3.rk_ready = 1'b0;
    #1;
    chk("rst_round_key", kx.round_key, 128'h0);
    chk("rst_round_idx", kx.round_idx, 4'd0);
    chk("rst_rk_valid", kx.rk_valid, 1'b0);
    chk("rst_busy", kx.busy, 1'b0);
    chk("rst_done", kx.done, 1'b0);
    chk("rst_last_key", kx.last_key, 128'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // model pins
    chk("model_sbox_00", sbox_model(8'h00), 8'h63);
    chk("model_sbox_53", sbox_model(8'h53), 8'hed);
    model_expand(KEY_ZERO);
    chk("model_zero_r1", mk[1], 128'h62636363626363636263636362636363);
    chk("model_zero_r10", mk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    model_expand(KEY_FIPS);
    chk("model_fips_r1", mk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_r3", mk[3], 128'h3d80477d4716fe3e1e237e446d7a883b);
    chk("model_fips_r10", mk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Test 1: FIPS key, ready held high, both instances
    kx.rk_ready = 1'b1; kx3.rk_ready = 1'b1;
    x0 = xfers; d0 = dones;
    kx.key_in = KEY_FIPS; kx3.key_in = KEY_FIPS;
    kx.start = 1'b1; kx3.start = 1'b1;
    @(posedge clk); #1;
    kx.start = 1'b0; kx3.start = 1'b0;
    chk("t1_r0_valid", kx.rk_valid, 1'b1);
    chk("t1_r0_idx", kx.round_idx, 4'd0);
    chk("t1_r0_key", kx.round_key, KEY_FIPS);
    chk("t1_busy", kx.busy, 1'b1);
    @(posedge clk); #1;
    chk("t1_r1_key", kx.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    lat = 2;
    while (!kx.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t1_start_to_done", lat, 12);
    chk("t1_done_busy", kx.busy, 1'b0);
    chk("t1_last_key", kx.last_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk); #1;
    chk("t1_xfers", xfers - x0, 11);
    chk("t1_dones", dones - d0, 1);
    chk("r3_xfers", xfers3, 4);
    chk("r3_dones", dones3, 1);
    chk("r3_last_key", kx3.last_key, 128'h3d80477d4716fe3e1e237e446d7a883b);
    @(posedge clk); #1;

    // Test 2: random backpressure with 5-cycle stalls at idx 0, 5, 10
    x0 = xfers; d0 = dones;
    kx.rk_ready = 1'b0;
    for (int i = 0; i < 16; i++) stalled[i] = 1'b0;
    pulse_start(KEY_FIPS);
    cyc = 0;
    while (!kx.done && cyc < 300) begin
      if (kx.rk_valid && (kx.round_idx == 4'd0 || kx.round_idx == 4'd5 || kx.round_idx == 4'd10)
          && !stalled[kx.round_idx]) begin
        stalled[kx.round_idx] = 1'b1;
        hold_key = kx.round_key;
        hold_idx = kx.round_idx;
        kx.rk_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cyc += 5;
        chk("t2_stall_key", kx.round_key, hold_key);
        chk("t2_stall_idx", kx.round_idx, hold_idx);
      end
      kx.rk_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    kx.rk_ready = 1'b1;
    chk("t2_done_seen", kx.done, 1'b1);
    @(negedge clk); #1;
    chk("t2_xfers", xfers - x0, 11);
    chk("t2_dones", dones - d0, 1);
    @(posedge clk); #1;

    // Test 3: zero key
    model_expand(KEY_ZERO);
    x0 = xfers;
    pulse_start(KEY_ZERO);
    chk("t3_r0_key", kx.round_key, KEY_ZERO);
    @(posedge clk); #1;
    chk("t3_r1_key", kx.round_key, 128'h62636363626363636263636362636363);
    wait_done(lat);
    chk("t3_last_key", kx.last_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    @(negedge clk); #1;
    chk("t3_xfers", xfers - x0, 11);
    @(posedge clk); #1;

    // Test 4: start held through EMIT and FINISH, accepted again in IDLE
    model_expand(KEY_FIPS);
    x0 = xfers; d0 = dones;
    kx.key_in = KEY_FIPS;
    kx.start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    chk("t4_start_to_done", lat, 12);
    @(negedge clk); #1;
    chk("t4_xfers", xfers - x0, 11);
    chk("t4_dones", dones - d0, 1);
    @(posedge clk); #1;
    chk("t4_finish_start_dropped", kx.rk_valid, 1'b0);
    @(posedge clk); #1;
    kx.start = 1'b0;
    chk("t4_restart_valid", kx.rk_valid, 1'b1);
    chk("t4_restart_idx", kx.round_idx, 4'd0);

    // Test 5: asynchronous reset at round_idx 4
    cyc = 0;
    while (kx.round_idx != 4'd4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_reached_idx4", kx.round_idx, 4'd4);
    d0 = dones;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_round_key", kx.round_key, 128'h0);
    chk("t5_rst_round_idx", kx.round_idx, 4'd0);
    chk("t5_rst_rk_valid", kx.rk_valid, 1'b0);
    chk("t5_rst_busy", kx.busy, 1'b0);
    chk("t5_rst_done", kx.done, 1'b0);
    chk("t5_rst_last_key", kx.last_key, 128'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("t5_no_done", dones - d0, 0);
    chk("t5_idle_valid", kx.rk_valid, 1'b0);
    x0 = xfers; d0 = dones;
    pulse_start(KEY_FIPS);
    chk("t5_fresh_idx", kx.round_idx, 4'd0);
    chk("t5_fresh_key", kx.round_key, KEY_FIPS);
    wait_done(lat);
    chk("t5_start_to_done", lat, 12);
    @(negedge clk); #1;
    chk("t5_xfers", xfers - x0, 11);
    chk("t5_dones", dones - d0, 1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
